weight_pingpong_buffer: RTL



---
 rtl/weight_buf_pkg.sv | 13 +
 rtl/weight_buf_bank.sv | 26 ++
 rtl/weight_pingpong_buffer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/weight_buf_pkg.sv
// Shared types for the double-buffered weight store: per-bank lifecycle state
// and the bank count.
package weight_buf_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY = 2'd0,
        BANK_FILL  = 2'd1,
        BANK_FULL  = 2'd2
    } bank_state_t;

    localparam int NUM_BANKS = 2;

endpackage

// File: rtl/weight_buf_bank.sv
// Single-port synchronous weight RAM with registered read data; this is the
// drop-in point for a compiled SRAM macro.
module weight_buf_bank #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset so it maps onto a plain SRAM; every word is
    // written before a tile can be read, and out-of-tile reads are masked above.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/weight_pingpong_buffer.sv
// Two-bank ping-pong weight store: the loader fills one bank while the compute
// array reads the other; banks change hands through tile close and release.
module weight_pingpong_buffer
    import weight_buf_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_release,
    output logic              bank_ready,
    output logic [ADDR_W:0]   rd_count
);

    bank_state_t       state_q [NUM_BANKS];
    bank_state_t       state_d [NUM_BANKS];
    logic [ADDR_W:0]   count_q [NUM_BANKS];
    logic [ADDR_W:0]   count_d [NUM_BANKS];
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;

    logic              rd_valid_q, rd_sel_q, rd_zero_q;
    logic [DATA_W-1:0] hold_q;

    logic              wr_accept, wr_close, rd_fire, rel_fire;
    logic              bank_we    [NUM_BANKS];
    logic [ADDR_W-1:0] bank_addr  [NUM_BANKS];
    logic [DATA_W-1:0] bank_rdata [NUM_BANKS];

    assign wr_ready   = (state_q[wr_bank_q] != BANK_FULL);
    assign bank_ready = (state_q[rd_bank_q] == BANK_FULL);
    assign rd_count   = bank_ready ? count_q[rd_bank_q] : '0;

    assign wr_accept = wr_valid && wr_ready;
    assign wr_close  = wr_accept && (wr_last || (wr_ptr_q == ADDR_W'(DEPTH - 1)));
    assign rd_fire   = rd_en && bank_ready;
    assign rel_fire  = rd_release && bank_ready;

    // NOTE: every next-state variable takes its current value first, so no
    // path through this block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_ptr_d  = wr_ptr_q;
        if (wr_accept) begin
            state_d[wr_bank_q] = BANK_FILL;
            wr_ptr_d           = wr_ptr_q + ADDR_W'(1);
            if (wr_close) begin
                state_d[wr_bank_q] = BANK_FULL;
                count_d[wr_bank_q] = {1'b0, wr_ptr_q} + (ADDR_W + 1)'(1);
                wr_bank_d          = ~wr_bank_q;
                wr_ptr_d           = '0;
            end
        end
        // The released bank is never the one being written, so both updates stand.
        if (rel_fire) begin
            state_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d          = ~rd_bank_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b] <= BANK_EMPTY;
                count_q[b] <= '0;
            end
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    // Read side remembers which bank was read and whether the address fell
    // past the tile; hold_q keeps the last delivered word between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_sel_q   <= 1'b0;
            rd_zero_q  <= 1'b0;
            hold_q     <= '0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_sel_q  <= rd_bank_q;
                rd_zero_q <= ({1'b0, rd_addr} >= count_q[rd_bank_q]);
            end
            if (rd_valid_q) begin
                hold_q <= rd_data;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = !rd_valid_q ? hold_q :
                      (rd_zero_q ? '0 : bank_rdata[rd_sel_q]);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign bank_we[b]   = wr_accept && (wr_bank_q == 1'(b));
        assign bank_addr[b] = (state_q[b] == BANK_FULL) ? rd_addr : wr_ptr_q;

        weight_buf_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .addr  (bank_addr[b]),
            .wdata (wr_data),
            .rdata (bank_rdata[b])
        );
    end

endmodule
